// File: rtl/mem_slave_ws.sv
// rtl/mem_slave_ws.sv - word-addressed memory slave with configurable wait states and byte strobes
module mem_slave_ws #(
  parameter int WIDTH       = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 2 ** ADDR_WIDTH,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  valid,
  input  logic                  wr_rd,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [WIDTH/8-1:0]    wstrb,
  output logic                  ready,
  output logic [WIDTH-1:0]      rdata,
  output logic                  rvalid,
  output logic                  err
);

  localparam int NB    = WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable in the range compare.
  localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [3:0]          CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]        wdata_q, wdata_d;
  logic [NB-1:0]           wstrb_q, wstrb_d;
  logic                    ready_q, ready_d;
  logic                    rvalid_q, rvalid_d;
  logic                    err_q, err_d;
  logic [WIDTH-1:0]        rdata_q, rdata_d;

  logic                    hit;
  logic                    enter_ack;
  logic                    mem_we;
  logic [IDX_W-1:0]        idx;

  logic [WIDTH-1:0]        mem [DEPTH];

  // The request copy used for the access: live inputs on the latching edge,
  // the held copy afterwards, so WAIT_STATES=0 sees the same values as the
  // longer paths.
  assign idx = addr_d[IDX_W-1:0];
  assign hit = ({1'b0, addr_d} < DEPTH_L);

  // State, counter, latched request and registered outputs.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // Next-state logic plus the completion outputs for the cycle spent in ACK.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    ready_d   = 1'b0;
    rvalid_d  = 1'b0;
    err_d     = 1'b0;
    rdata_d   = rdata_q;
    mem_we    = 1'b0;
    enter_ack = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (valid) begin
          wr_d    = wr_rd;
          addr_d  = addr;
          wdata_d = wdata;
          wstrb_d = wstrb;
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = S_ACK;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK: begin
        // No new request is taken here; a held valid is seen again in IDLE.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    enter_ack = (state_d == S_ACK) && (state_q != S_ACK);

    if (enter_ack) begin
      ready_d = 1'b1;
      err_d   = ~hit;
      if (wr_d) begin
        mem_we = hit;
      end else begin
        rvalid_d = 1'b1;
        rdata_d  = hit ? mem[idx] : '0;
      end
    end
  end

  // Byte-masked write on the ACK-entry edge; contents survive reset, and a
  // reset on that same edge drops the write.
  always_ff @(posedge clk) begin
    if (!res && mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (wstrb_d[b]) begin
          mem[idx][8*b +: 8] <= wdata_d[8*b +: 8];
        end
      end
    end
  end

  assign ready  = ready_q;
  assign rvalid = rvalid_q;
  assign err    = err_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_mem_slave_ws.sv
// tb/tb_mem_slave_ws.sv - randomized self-checking bench for mem_slave_ws against a behavioural memory model
module tb_mem_slave_ws;

  logic        clk = 1'b0;
  logic        res;
  logic        wr_rd;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        vld [3];
  logic        rdy [3];
  logic        rv  [3];
  logic        er  [3];
  logic [31:0] rd  [3];

  int          n_checks = 0;
  int          n_errors = 0;

  // Reference model: one plain word array per instance.
  logic [31:0] mm [3][256];
  logic [31:0] last_rd [3];
  int          ws_t  [3] = '{1, 0, 3};
  int          dep_t [3] = '{200, 256, 256};

  always #5 clk = ~clk;

  mem_slave_ws #(.WIDTH(32), .ADDR_WIDTH(8), .DEPTH(200), .WAIT_STATES(1)) u_dut1 (
    .clk(clk), .res(res), .valid(vld[0]), .wr_rd(wr_rd), .addr(addr), .wdata(wdata),
    .wstrb(wstrb), .ready(rdy[0]), .rdata(rd[0]), .rvalid(rv[0]), .err(er[0])
  );

  mem_slave_ws #(.WIDTH(32), .ADDR_WIDTH(8), .DEPTH(256), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .res(res), .valid(vld[1]), .wr_rd(wr_rd), .addr(addr), .wdata(wdata),
    .wstrb(wstrb), .ready(rdy[1]), .rdata(rd[1]), .rvalid(rv[1]), .err(er[1])
  );

  mem_slave_ws #(.WIDTH(32), .ADDR_WIDTH(8), .DEPTH(256), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .res(res), .valid(vld[2]), .wr_rd(wr_rd), .addr(addr), .wdata(wdata),
    .wstrb(wstrb), .ready(rdy[2]), .rdata(rd[2]), .rvalid(rv[2]), .err(er[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // One transaction on instance k; valid is dropped after the request cycle
  // and the shared inputs are scrambled while the slave is busy.
  task automatic txn(input int k, input logic w, input logic [7:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] got);
    int          n;
    logic        inr;
    logic [31:0] exp;
    @(negedge clk);
    wr_rd = w; addr = a; wdata = d; wstrb = s; vld[k] = 1'b1;
    @(negedge clk);
    vld[k] = 1'b0;
    wr_rd = 1'($urandom); addr = 8'($urandom); wdata = $urandom; wstrb = 4'($urandom);
    n = 1;
    while (!rdy[k] && n < 40) begin
      @(negedge clk);
      n++;
    end
    inr = (int'(a) < dep_t[k]);
    check("latency", 32'(n), 32'(ws_t[k] + 1));
    check("err", 32'(er[k]), 32'(!inr));
    check("rvalid", 32'(rv[k]), 32'(!w));
    if (w) begin
      check("rdata_hold", rd[k], last_rd[k]);
      if (inr) mm[k][a] = merge(mm[k][a], d, s);
    end else begin
      exp = inr ? mm[k][a] : 32'h0;
      check("rdata", rd[k], exp);
      last_rd[k] = exp;
    end
    got = rd[k];
    @(negedge clk);
    check("ready_one_cycle", 32'(rdy[k]), 32'h0);
    check("rvalid_one_cycle", 32'(rv[k]), 32'h0);
  endtask

  initial begin
    logic [31:0] got;
    res = 1'b1; wr_rd = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    for (int k = 0; k < 3; k++) begin
      vld[k] = 1'b0;
      last_rd[k] = 32'h0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_ready", 32'(rdy[k]), 32'h0);
      check("rst_rvalid", 32'(rv[k]), 32'h0);
      check("rst_err", 32'(er[k]), 32'h0);
      check("rst_rdata", rd[k], 32'h0);
    end
    res = 1'b0;

    // Give every implemented word a known value.
    for (int k = 0; k < 3; k++)
      for (int a = 0; a < 256; a++)
        txn(k, 1'b1, 8'(a), $urandom, 4'hF, got);

    // Full write then read back.
    txn(0, 1'b1, 8'h05, 32'hDEADBEEF, 4'hF, got);
    txn(0, 1'b0, 8'h05, 32'h0, 4'h0, got);
    check("req33_rdata", got, 32'hDEADBEEF);

    // Partial strobe merge.
    txn(0, 1'b1, 8'h0A, 32'h11223344, 4'hF, got);
    txn(0, 1'b1, 8'h0A, 32'hAABBCCDD, 4'h5, got);
    txn(0, 1'b0, 8'h0A, 32'h0, 4'h0, got);
    check("req34_rdata", got, 32'h11BB33DD);

    // Out of range on the DEPTH=200 instance; the aliased low word must not move.
    txn(0, 1'b1, 8'hC8, 32'hFFFFFFFF, 4'hF, got);
    txn(0, 1'b0, 8'hC8, 32'h0, 4'h0, got);
    check("req35_rdata", got, 32'h0);
    txn(0, 1'b0, 8'h48, 32'h0, 4'h0, got);

    // Zero-strobe write completes and changes nothing.
    txn(2, 1'b1, 8'h21, 32'hCAFEF00D, 4'h0, got);
    txn(2, 1'b0, 8'h21, 32'h0, 4'h0, got);

    // Valid held on the zero-wait instance: ready every second cycle.
    @(negedge clk);
    wr_rd = 1'b0; addr = 8'h10; vld[1] = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      check("held_ready", 32'(rdy[1]), 32'(c % 2 == 1 && c <= 7));
      if (c % 2 == 1 && c <= 7) check("held_rdata", rd[1], mm[1][8'h10]);
      if (c == 7) vld[1] = 1'b0;
    end
    last_rd[1] = mm[1][8'h10];

    // Reset during WAIT of a write: no completion, no commit.
    @(negedge clk);
    wr_rd = 1'b1; addr = 8'h03; wdata = ~mm[0][3]; wstrb = 4'hF; vld[0] = 1'b1;
    @(negedge clk);
    vld[0] = 1'b0; res = 1'b1;
    @(negedge clk);
    check("rst_abort_ready", 32'(rdy[0]), 32'h0);
    check("rst_abort_rdata", rd[0], 32'h0);
    vld[0] = 1'b1;
    @(negedge clk);
    res = 1'b0; vld[0] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("rst_no_ready", 32'(rdy[0]), 32'h0);
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) last_rd[k] = 32'h0;
    txn(0, 1'b0, 8'h03, 32'h0, 4'h0, got);
    check("req37_rdata", got, mm[0][3]);

    // Read with valid dropped after one cycle on the three-wait instance.
    txn(2, 1'b1, 8'h44, 32'h13579BDF, 4'hF, got);
    txn(2, 1'b0, 8'h44, 32'h0, 4'h0, got);
    check("req38_rdata", got, 32'h13579BDF);

    // Randomized traffic across all instances.
    for (int i = 0; i < 300; i++) begin
      txn($urandom_range(0, 2), 1'($urandom), 8'($urandom), $urandom, 4'($urandom), got);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_slave_ws.md
MEM_SLAVE_WS -- requirements
Module: mem_slave_ws

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, address width in bits.
REQ-003 SHALL have parameter DEPTH, default 2**ADDR_WIDTH, number of words implemented; must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH.
REQ-004 SHALL have parameter WAIT_STATES, default 1, cycles inserted before ready; legal range 0..15.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 SHALL have port res, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port valid, input, 1 bit: request present.
REQ-008 SHALL have port wr_rd, input, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have port addr, input, ADDR_WIDTH bits: word address.
REQ-010 SHALL have port wdata, input, WIDTH bits: write data.
REQ-011 SHALL have port wstrb, input, WIDTH/8 bits: byte enables for writes; bit i covers wdata[8i+7:8i].
REQ-012 SHALL have port ready, output, 1 bit: transaction complete, pulsed for one cycle.
REQ-013 SHALL have port rdata, output, WIDTH bits: read data.
REQ-014 SHALL have port rvalid, output, 1 bit: rdata valid, asserted only in read-completion cycle.
REQ-015 SHALL have port err, output, 1 bit: address out of range, asserted only in completion cycle.

Function
REQ-016 SHALL implement FSM with states IDLE, WAIT, ACK; all outputs registered.
REQ-017 SHALL, in IDLE with valid=1 at a rising edge, latch wr_rd, addr, wdata and wstrb.
REQ-018 SHALL, on that latching edge, go to WAIT with counter loaded to WAIT_STATES-1 if WAIT_STATES>0, else go directly to ACK.
REQ-019 SHALL, in WAIT, decrement the counter each cycle and go to ACK on the edge where the counter equals 0.
REQ-020 SHALL drive ready=1 for exactly one cycle, in ACK, then return to IDLE unconditionally.
REQ-021 SHALL produce request-to-ready latency of WAIT_STATES+1 cycles; back-to-back transactions therefore start no faster than every WAIT_STATES+2 cycles.
REQ-022 SHALL commit writes on the edge entering ACK, updating only bytes whose wstrb bit is 1.
REQ-023 SHALL load rdata with mem[addr] on the edge entering ACK for reads, and assert rvalid=1 in ACK.
REQ-024 SHALL keep rdata unchanged outside read ACK cycles, including across writes.
REQ-025 SHALL, when latched addr >= DEPTH, suppress the write, load rdata=0 on reads, and assert err=1 in ACK.
REQ-026 SHALL ignore valid and input changes while in WAIT or ACK; the transaction completes using the latched copy even if valid drops.
REQ-027 SHALL treat a write with wstrb=0 as a legal no-op write that still completes with ready.
REQ-028 SHALL not accept a new request in the ACK cycle; a held valid is sampled again in the following IDLE cycle.

Reset
REQ-029 SHALL, on res=1 at a rising edge, force state IDLE, ready=0, rvalid=0, err=0, rdata=0 and wait counter=0, overriding any pending transition.
REQ-030 SHALL abort an in-flight transaction on reset, with no write committed if reset coincides with the ACK-entry edge.
REQ-031 SHALL not clear memory contents on reset.
REQ-032 SHALL ignore valid in any cycle where res=1.

Verification
REQ-033 SHALL cover: WAIT_STATES=1, write addr 0x05 data 0xDEADBEEF wstrb 0xF, then read 0x05 -> ready 2 cycles after valid, rdata=0xDEADBEEF, rvalid=1, err=0.
REQ-034 SHALL cover: over 0x11223344 at 0x0A, write 0xAABBCCDD wstrb 0x5, read 0x0A -> rdata=0x11BB33DD.
REQ-035 SHALL cover: DEPTH=200, write 0xFFFFFFFF then read at addr 0xC8 -> err=1 both times, read rdata=0, no array change.
REQ-036 SHALL cover: WAIT_STATES=0, valid held high for 4 transactions -> ready pulses every 2nd cycle, never on consecutive cycles.
REQ-037 SHALL cover: res asserted during WAIT of a write to 0x03 -> ready never pulses, later read of 0x03 returns prior contents.
REQ-038 SHALL cover: WAIT_STATES=3, valid dropped after one cycle on a read -> ready, rvalid asserted 4 cycles after valid with correct rdata.
